// File: rtl/gpu_host_pkg.sv
// Shared types and constants for the host-to-GPU/DSP bridge.
package gpu_host_pkg;

   // Bridge sequencer states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRREQ  = 2'd1,
      RDREQ  = 2'd2,
      RDDONE = 2'd3
   } state_t;

   // io_addr[1] encoding: the high half is addressed first
   localparam logic HALF_HI = 1'b0;
   localparam logic HALF_LO = 1'b1;

   // Widths of the default configuration (32-bit bus, 16-bit host address)
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 16;

   // Posted-write entry as seen by the default configuration
   typedef struct packed {
      logic [DEF_ADDR_W-3:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } wr_entry_t;

endpackage

// File: rtl/gpu_host_wfifo.sv
// Small synchronous FIFO holding posted host writes {word address, data}.
module gpu_host_wfifo #(
   parameter int WIDTH = 46,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [LVL_W-1:0] count_reg;
   logic             push_ok;
   logic             pop_ok;

   // Full/empty come from the registered count only, so a pop never frees a slot the same cycle
   assign full    = (count_reg == LVL_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign level   = count_reg;
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rd_ptr_reg];

   // Pointers wrap naturally (DEPTH is a power of two); count tracks push minus pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         count_reg <= count_reg + LVL_W'(push_ok) - LVL_W'(pop_ok);
      end
   end

   // Storage array; contents need no reset because the pointers define validity
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg] <= din;
   end

endmodule

// File: rtl/gpu_host_bridge.sv
// Host I/O to GPU/DSP local-bus bridge: half-word write assembly, posted write
// FIFO, and split reads served from a low-half latch when possible.
module gpu_host_bridge
   import gpu_host_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic                       sys_clk,
   input  logic                       reset_n,
   input  logic [ADDR_W-1:0]          io_addr,
   input  logic                       iowr,
   input  logic                       iord,
   input  logic                       big_io,
   input  logic [DATA_W-1:0]          dwrite,
   output logic                       io_wait,
   output logic [DATA_W-1:0]          dread_out,
   output logic                       dread_oe,
   output logic [ADDR_W-3:0]          cpuaddr,
   output logic [DATA_W-1:0]          cpudata,
   output logic                       cpuwr,
   output logic                       ioreq,
   input  logic                       ack,
   input  logic [DATA_W-1:0]          mem_data,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

   localparam int HOST_W = DATA_W / 2;
   localparam int WA_W   = ADDR_W - 2;
   localparam int ENT_W  = WA_W + DATA_W;
   localparam int LVL_W  = $clog2(DEPTH+1);

   state_t            state_reg, state_next;
   logic [WA_W-1:0]   word_addr;
   logic              half_sel;
   logic              addr_unused;
   logic              fifo_full, fifo_empty;
   logic [LVL_W-1:0]  level_int;
   logic [ENT_W-1:0]  fifo_din, fifo_dout;
   logic [WA_W-1:0]   head_addr;
   logic [DATA_W-1:0] head_data;
   logic [DATA_W-1:0] push_data;
   logic              push_en, hi_latch_en, pop_en;
   logic              lo_hit, rd_start;

   logic [HOST_W-1:0] hi_hold_reg;
   logic [HOST_W-1:0] lo_latch_reg;
   logic [WA_W-1:0]   lo_addr_reg;
   logic              lo_valid_reg;
   logic [WA_W-1:0]   rd_addr_reg;
   logic              rd_big_reg;
   logic              rd_half_reg;
   logic [DATA_W-1:0] rd_data_reg;

   assign word_addr   = io_addr[ADDR_W-1:2];
   assign half_sel    = io_addr[1];
   assign addr_unused = io_addr[0];

   // A high-half strobe only fills hi_hold; full words and low halves are posted
   assign push_en     = iowr & ~fifo_full & (big_io | (half_sel == HALF_LO));
   assign hi_latch_en = iowr & ~fifo_full & ~big_io & (half_sel == HALF_HI);
   assign push_data   = big_io ? dwrite : {hi_hold_reg, dwrite[HOST_W-1:0]};
   assign fifo_din    = {word_addr, push_data};
   assign head_addr   = fifo_dout[ENT_W-1:DATA_W];
   assign head_data   = fifo_dout[DATA_W-1:0];
   assign pop_en      = (state_reg == WRREQ) & ack;
   assign fifo_level  = level_int;

   // Second half of a split read whose word was just fetched needs no bus cycle
   assign lo_hit   = ~big_io & (half_sel == HALF_LO) & lo_valid_reg & (word_addr == lo_addr_reg);
   // Reads wait for the FIFO to drain, including a write accepted this very cycle
   assign rd_start = (state_reg == IDLE) & fifo_empty & iord & ~push_en;

   assign io_wait = (iowr & fifo_full) | (iord & ~dread_oe);

   gpu_host_wfifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_wfifo (
      .clk   (sys_clk),
      .rst_n (reset_n),
      .push  (push_en),
      .din   (fifo_din),
      .pop   (pop_en),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level_int)
   );

   // State register; reset returns to IDLE so ioreq drops immediately
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   // Next-state and local-bus / host-read outputs
   always_comb begin
      state_next = state_reg;
      ioreq      = 1'b0;
      cpuwr      = 1'b0;
      cpuaddr    = '0;
      cpudata    = '0;
      dread_oe   = 1'b0;
      dread_out  = '0;
      case (state_reg)
         IDLE: begin
            if (!fifo_empty)   state_next = WRREQ;
            else if (rd_start) state_next = lo_hit ? RDDONE : RDREQ;
         end
         WRREQ: begin
            ioreq   = 1'b1;
            cpuwr   = 1'b1;
            cpuaddr = head_addr;
            cpudata = head_data;
            if (ack) state_next = ((level_int > LVL_W'(1)) || push_en) ? WRREQ : IDLE;
         end
         RDREQ: begin
            ioreq   = 1'b1;
            cpuaddr = rd_addr_reg;
            if (ack) state_next = RDDONE;
         end
         RDDONE: begin
            dread_oe = 1'b1;
            if (rd_big_reg)                dread_out = rd_data_reg;
            else if (rd_half_reg == HALF_HI) dread_out = {{HOST_W{1'b0}}, rd_data_reg[DATA_W-1:HOST_W]};
            else                           dread_out = {{HOST_W{1'b0}}, rd_data_reg[HOST_W-1:0]};
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Write-assembly, read-request capture and low-half latch bookkeeping
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         hi_hold_reg  <= '0;
         lo_latch_reg <= '0;
         lo_addr_reg  <= '0;
         lo_valid_reg <= 1'b0;
         rd_addr_reg  <= '0;
         rd_big_reg   <= 1'b0;
         rd_half_reg  <= 1'b0;
         rd_data_reg  <= '0;
      end else begin
         if (hi_latch_en) hi_hold_reg <= dwrite[HOST_W-1:0];
         if (rd_start) begin
            rd_addr_reg <= word_addr;
            rd_big_reg  <= big_io;
            rd_half_reg <= half_sel;
            if (lo_hit) begin
               rd_data_reg  <= {{HOST_W{1'b0}}, lo_latch_reg};
               lo_valid_reg <= 1'b0;
            end
         end
         if ((state_reg == RDREQ) && ack) begin
            rd_data_reg  <= mem_data;
            lo_latch_reg <= mem_data[HOST_W-1:0];
            lo_addr_reg  <= rd_addr_reg;
            lo_valid_reg <= 1'b1;
         end
         // A newer write to the latched word makes the latch stale; this wins over a fill
         if (push_en && (word_addr == lo_addr_reg)) lo_valid_reg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gpu_host_bridge.sv
// Directed testbench for gpu_host_bridge (DATA_W=32, ADDR_W=16, DEPTH=4).
module tb_gpu_host_bridge;
   import gpu_host_pkg::*;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 16;
   localparam int DEPTH  = 4;

   logic        sys_clk;
   logic        reset_n;
   logic [15:0] io_addr;
   logic        iowr, iord, big_io;
   logic [31:0] dwrite;
   logic        io_wait;
   logic [31:0] dread_out;
   logic        dread_oe;
   logic [13:0] cpuaddr;
   logic [31:0] cpudata;
   logic        cpuwr, ioreq, ack;
   logic [31:0] mem_data;
   logic [2:0]  fifo_level;

   int n_checks = 0;
   int n_fail   = 0;

   gpu_host_bridge #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) dut (
      .sys_clk    (sys_clk),
      .reset_n    (reset_n),
      .io_addr    (io_addr),
      .iowr       (iowr),
      .iord       (iord),
      .big_io     (big_io),
      .dwrite     (dwrite),
      .io_wait    (io_wait),
      .dread_out  (dread_out),
      .dread_oe   (dread_oe),
      .cpuaddr    (cpuaddr),
      .cpudata    (cpudata),
      .cpuwr      (cpuwr),
      .ioreq      (ioreq),
      .ack        (ack),
      .mem_data   (mem_data),
      .fifo_level (fifo_level)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, obs);
      end
   endtask

   task automatic cyc();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic host_write(input logic [15:0] addr, input logic [31:0] data, input logic big);
      io_addr = addr;
      dwrite  = data;
      big_io  = big;
      iowr    = 1'b1;
      cyc();
      iowr    = 1'b0;
   endtask

   // Issues a read, acks any write cycles at once, acks the read after ack_gap extra cycles
   task automatic host_read(input logic [15:0] addr, input logic big, input int ack_gap,
                            input logic [31:0] mem, input logic also_wr, input logic [31:0] wdata,
                            output logic [31:0] data, output logic used_bus,
                            output int wbr, output int lat);
      int   wr_done   = 0;
      int   rd_cycles = 0;
      logic got       = 1'b0;
      io_addr  = addr;
      big_io   = big;
      mem_data = mem;
      iord     = 1'b1;
      used_bus = 1'b0;
      wbr      = -1;
      lat      = 0;
      data     = '0;
      if (also_wr) begin
         dwrite = wdata;
         iowr   = 1'b1;
      end
      for (int n = 1; n <= 60 && !got; n++) begin
         if (ioreq && cpuwr) begin
            ack = 1'b1;
            wr_done++;
         end else if (ioreq) begin
            if (!used_bus) wbr = wr_done;
            used_bus = 1'b1;
            rd_cycles++;
            ack = (rd_cycles > ack_gap);
         end else begin
            ack = 1'b0;
         end
         cyc();
         iowr = 1'b0;
         if (dread_oe) begin
            got  = 1'b1;
            lat  = n;
            data = dread_out;
         end
      end
      iord = 1'b0;
      ack  = 1'b0;
      check("read_completed", {31'd0, got}, 32'd1);
      cyc();
      check("dread_oe_one_cycle", {31'd0, dread_oe}, 32'd0);
   endtask

   initial begin : stim
      logic [31:0] rdata;
      logic        used;
      int          wbr, lat, nw;
      logic        seen;
      wr_entry_t   exp_q [4];
      wr_entry_t   got_q [4];

      reset_n = 1'b0; io_addr = '0; iowr = 0; iord = 0; big_io = 0;
      dwrite = '0; ack = 0; mem_data = '0;
      repeat (3) cyc();
      check("rst_ioreq",      {31'd0, ioreq}, 32'd0);
      check("rst_dread_oe",   {31'd0, dread_oe}, 32'd0);
      check("rst_dread_out",  dread_out, 32'd0);
      check("rst_cpuaddr",    {18'd0, cpuaddr}, 32'd0);
      check("rst_fifo_level", {29'd0, fifo_level}, 32'd0);
      check("rst_io_wait",    {31'd0, io_wait}, 32'd0);
      reset_n = 1'b1;
      cyc();

      // 1: half-word assembly into one posted write
      host_write(16'h0100, 32'h0000_1234, 1'b0);
      check("t1_level_after_hi", {29'd0, fifo_level}, 32'd0);
      host_write(16'h0102, 32'h0000_5678, 1'b0);
      check("t1_level_after_lo", {29'd0, fifo_level}, 32'd1);
      cyc();
      check("t1_ioreq",   {31'd0, ioreq}, 32'd1);
      check("t1_cpuwr",   {31'd0, cpuwr}, 32'd1);
      check("t1_cpuaddr", {18'd0, cpuaddr}, 32'h040);
      check("t1_cpudata", cpudata, 32'h1234_5678);
      ack = 1'b1;
      cyc();
      ack = 1'b0;
      check("t1_level_after_ack", {29'd0, fifo_level}, 32'd0);
      check("t1_ioreq_done",      {31'd0, ioreq}, 32'd0);

      // 2: fill the FIFO with ack held low, fifth strobe is stalled, then drain in order
      for (int i = 0; i < 4; i++) begin
         exp_q[i].addr = 14'h400 + 14'(i);
         exp_q[i].data = 32'hA000_0000 + 32'(i);
         host_write(16'h1000 + 16'(4 * i), exp_q[i].data, 1'b1);
      end
      io_addr = 16'h1010; dwrite = 32'hA000_0004; big_io = 1'b1; iowr = 1'b1;
      #1;
      check("t2_io_wait_full", {31'd0, io_wait}, 32'd1);
      check("t2_level_full",   {29'd0, fifo_level}, 32'd4);
      cyc();
      iowr = 1'b0;
      check("t2_level_after_reject", {29'd0, fifo_level}, 32'd4);
      nw = 0;
      for (int n = 0; n < 20; n++) begin
         if (ioreq && cpuwr) begin
            if (nw < 4) begin
               got_q[nw].addr = cpuaddr;
               got_q[nw].data = cpudata;
            end
            nw++;
         end else if (nw > 0) begin
            break;
         end
         ack = 1'b1;
         cyc();
      end
      ack = 1'b0;
      check("t2_write_count", nw, 32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_addr%0d", i), {18'd0, got_q[i].addr}, {18'd0, exp_q[i].addr});
         check($sformatf("t2_data%0d", i), got_q[i].data, exp_q[i].data);
      end
      check("t2_level_drained", {29'd0, fifo_level}, 32'd0);

      // 3: split read, high half from the bus, low half from the latch
      host_read(16'h0200, 1'b0, 3, 32'hCAFE_BABE, 1'b0, 32'd0, rdata, used, wbr, lat);
      check("t3_hi_data",  rdata, 32'h0000_CAFE);
      check("t3_hi_bus",   {31'd0, used}, 32'd1);
      check("t3_latency",  lat, 32'd5);
      host_read(16'h0202, 1'b0, 0, 32'h0, 1'b0, 32'd0, rdata, used, wbr, lat);
      check("t3_lo_data",  rdata, 32'h0000_BABE);
      check("t3_lo_nobus", {31'd0, used}, 32'd0);
      check("t3_lo_latency", lat, 32'd1);

      // 4: writes drain before the read; an intervening write invalidates the latch
      host_write(16'h0300, 32'h1111_1111, 1'b1);
      host_write(16'h0304, 32'h2222_2222, 1'b1);
      host_read(16'h0300, 1'b1, 0, 32'h3333_3333, 1'b0, 32'd0, rdata, used, wbr, lat);
      check("t4_writes_first", wbr, 32'd2);
      check("t4_big_data",     rdata, 32'h3333_3333);
      host_read(16'h0200, 1'b0, 0, 32'hDEAD_0001, 1'b0, 32'd0, rdata, used, wbr, lat);
      check("t4_hi_data", rdata, 32'h0000_DEAD);
      host_write(16'h0200, 32'h5555_6666, 1'b1);
      host_read(16'h0202, 1'b0, 0, 32'h7777_8888, 1'b0, 32'd0, rdata, used, wbr, lat);
      check("t4_lo_refetch_bus", {31'd0, used}, 32'd1);
      check("t4_lo_refetch_wbr", wbr, 32'd1);
      check("t4_lo_data",        rdata, 32'h0000_8888);

      // 7: simultaneous write and read strobe, write goes first
      host_read(16'h0400, 1'b1, 1, 32'h4444_4444, 1'b1, 32'h9999_9999, rdata, used, wbr, lat);
      check("t7_write_first", wbr, 32'd1);
      check("t7_data",        rdata, 32'h4444_4444);

      // 5: asynchronous reset while a write cycle is on the bus
      host_write(16'h0500, 32'h0000_0001, 1'b1);
      host_write(16'h0504, 32'h0000_0002, 1'b1);
      host_write(16'h0508, 32'h0000_0003, 1'b1);
      check("t5_ioreq_before", {31'd0, ioreq}, 32'd1);
      check("t5_level_before", {29'd0, fifo_level}, 32'd3);
      #2 reset_n = 1'b0;
      #1;
      check("t5_ioreq_async", {31'd0, ioreq}, 32'd0);
      check("t5_level_async", {29'd0, fifo_level}, 32'd0);
      cyc();
      reset_n = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 5; n++) begin
         cyc();
         if (ioreq) seen = 1'b1;
      end
      check("t5_no_ioreq_after_rst", {31'd0, seen}, 32'd0);
      host_write(16'h0902, 32'h0000_4321, 1'b0);
      seen = 1'b0;
      for (int n = 0; n < 4 && !seen; n++) begin
         if (ioreq) seen = 1'b1;
         else cyc();
      end
      check("t5_new_ioreq",    {31'd0, seen}, 32'd1);
      check("t5_hi_hold_zero", cpudata, 32'h0000_4321);
      check("t5_cpuaddr",      {18'd0, cpuaddr}, 32'h240);
      ack = 1'b1;
      cyc();
      ack = 1'b0;

      // 6: stray ack in IDLE
      ack = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 3; n++) begin
         cyc();
         if (dread_oe || ioreq || fifo_level != 3'd0) seen = 1'b1;
      end
      ack = 1'b0;
      check("t6_stray_ack_quiet", {31'd0, seen}, 32'd0);
      check("t6_level",           {29'd0, fifo_level}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
